sram_controller: RTL and testbench

Bridges the cache controller's 32-bit request port to the board's asynchronous 16-bit external SRAM. It serializes each 64-bit block read into four halfword accesses and each 32-bit write into two, using fixed wait states. It presents a single `ready` handshake back to the cache. Downstream of the cache controller, upstream of the SRAM pins.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/sram_slot_counter.sv | 51 +++++
 rtl/sram_controller.sv | 156 +++++++++++++++
 tb/tb_sram_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-SRAM bridge: FSM encoding, external bus
// geometry, slot counts and the halfword base-address helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int SRAM_DW  = 16;
  localparam int SRAM_AW  = 18;
  localparam int RD_SLOTS = 4;
  localparam int WR_SLOTS = 2;
  localparam int SLOT_W   = 2;

  // Takes byte address bits [18:2]; reads align to a 4-halfword block, writes to a pair.
  function automatic logic [SRAM_AW-1:0] base_hw(input logic [16:0] addr_18_2, input logic is_wr);
    if (is_wr) begin
      return {addr_18_2, 1'b0};
    end
    return {addr_18_2[16:1], 2'b00};
  endfunction

endpackage

// File: rtl/sram_slot_counter.sv
// Cycle-within-slot and slot-index counters for one serialized SRAM operation;
// held at zero whenever run is low.
module sram_slot_counter #(
  parameter int  ACCESS_CYCLES = 2,
  parameter int  SLOTS         = 4,
  localparam int CW            = $clog2(ACCESS_CYCLES),
  localparam int SW            = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [SW-1:0] last_idx,
  output logic [CW-1:0] cycle,
  output logic [SW-1:0] slot,
  output logic          last_cycle,
  output logic          last_slot
);

  logic [CW-1:0] cycle_q, cycle_d;
  logic [SW-1:0] slot_q, slot_d;

  assign cycle      = cycle_q;
  assign slot       = slot_q;
  assign last_cycle = (cycle_q == CW'(ACCESS_CYCLES - 1));
  assign last_slot  = (slot_q == last_idx);

  always_comb begin
    cycle_d = '0;
    slot_d  = '0;
    if (run) begin
      if (last_cycle) begin
        cycle_d = '0;
        slot_d  = last_slot ? '0 : slot_q + 1'b1;
      end else begin
        cycle_d = cycle_q + 1'b1;
        slot_d  = slot_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      slot_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Bridges the cache's 32-bit request port to a 16-bit asynchronous SRAM:
// 64-bit block reads as four halfword slots, 32-bit writes as two.
module sram_controller
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          address,
  input  logic [31:0]          writeData,
  input  logic                 wrEn,
  input  logic                 rdEn,
  output logic [63:0]          readData,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N
);

  localparam int CW = $clog2(ACCESS_CYCLES);

  state_e               state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic [SRAM_AW-1:0]   base_q, base_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;

  logic                 req;
  logic [CW-1:0]        cycle;
  logic [SLOT_W-1:0]    slot;
  logic                 last_cycle;
  logic                 last_slot;
  logic                 capture;
  logic                 unused_addr_bits;

  assign req              = wrEn | rdEn;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  sram_slot_counter #(
    .ACCESS_CYCLES (ACCESS_CYCLES),
    .SLOTS         (RD_SLOTS)
  ) u_slot_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (state_q == ST_ACCESS),
    .last_idx   (is_wr_q ? SLOT_W'(WR_SLOTS - 1) : SLOT_W'(RD_SLOTS - 1)),
    .cycle      (cycle),
    .slot       (slot),
    .last_cycle (last_cycle),
    .last_slot  (last_slot)
  );

  // Strobe/address/data registers are loaded with the values for the *next*
  // cycle so the pins change exactly on slot and cycle boundaries.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_ACCESS;
          is_wr_d  = wrEn;
          base_d   = base_hw(address[18:2], wrEn);
          wdata_d  = writeData;
          addr_d   = base_hw(address[18:2], wrEn);
          we_n_d   = ~wrEn;
          oe_n_d   = wrEn;
          dq_oe_d  = wrEn;
          dq_out_d = writeData[15:0];
        end
      end
      ST_ACCESS: begin
        if (!last_cycle) begin
          // WE_N rises for the final cycle of a write slot to hold data.
          we_n_d  = ~is_wr_q | (cycle == CW'(ACCESS_CYCLES - 2));
          oe_n_d  = is_wr_q;
          dq_oe_d = is_wr_q;
        end else if (!last_slot) begin
          addr_d   = base_q + {{(SRAM_AW-SLOT_W){1'b0}}, slot} + 1'b1;
          we_n_d   = ~is_wr_q;
          oe_n_d   = is_wr_q;
          dq_oe_d  = is_wr_q;
          dq_out_d = wdata_q[31:16];
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      is_wr_q  <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign capture = (state_q == ST_ACCESS) && !is_wr_q && last_cycle;

  for (genvar gi = 0; gi < RD_SLOTS; gi++) begin : g_lane
    logic [SRAM_DW-1:0] lane_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (capture && (slot == SLOT_W'(gi))) begin
        lane_q <= SRAM_DQ;
      end
    end
    assign readData[gi*SRAM_DW +: SRAM_DW] = lane_q;
  end

  assign ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Two controllers (AC=2 and AC=3), each with a behavioural async SRAM, checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_sram_controller;

  localparam int AC0 = 2;
  localparam int AC1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] address_r [2];
  logic [31:0] wdata_r   [2];
  logic        wr_en     [2];
  logic        rd_en     [2];
  logic [63:0] rdata_w   [2];
  logic        ready_w   [2];
  logic [17:0] addr_w    [2];
  logic        we_n_w    [2];
  logic        oe_n_w    [2];
  logic        ce_n_w    [2];
  logic        ub_n_w    [2];
  logic        lb_n_w    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    wire [15:0] dq;
    bit  [15:0] mem [0:262143];

    // Asynchronous SRAM: drives on OE_N low (WE_N high), stores while WE_N low.
    assign dq = (!oe_n_w[gi] && we_n_w[gi]) ? mem[addr_w[gi]] : 16'hzzzz;
    always @(negedge clk) if (!we_n_w[gi]) mem[addr_w[gi]] <= dq;

    sram_controller #(.ACCESS_CYCLES(gi == 0 ? AC0 : AC1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address_r[gi]),
      .writeData (wdata_r[gi]),
      .wrEn      (wr_en[gi]),
      .rdEn      (rd_en[gi]),
      .readData  (rdata_w[gi]),
      .ready     (ready_w[gi]),
      .SRAM_DQ   (dq),
      .SRAM_ADDR (addr_w[gi]),
      .SRAM_WE_N (we_n_w[gi]),
      .SRAM_OE_N (oe_n_w[gi]),
      .SRAM_CE_N (ce_n_w[gi]),
      .SRAM_UB_N (ub_n_w[gi]),
      .SRAM_LB_N (lb_n_w[gi])
    );
  end

  function automatic int ac_of(input int i);
    return (i == 0) ? AC0 : AC1;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit [15:0]   ref_mem [2][0:262143];
  bit          m_valid [2];
  bit          m_busy  [2];
  bit          m_wr    [2];
  int          m_t0    [2];
  int unsigned m_base  [2];
  logic [31:0] m_wdata [2];
  logic [63:0] m_rd    [2];
  logic [63:0] m_exp   [2];
  logic [17:0] m_addr  [2];

  task automatic step(input int i, input logic rdy, input logic we_n, input logic oe_n,
                      input logic [17:0] a, input logic [63:0] rd, input logic [15:0] dq,
                      input logic [2:0] fixed_n);
    int e, k, s, ph, n, ac;
    logic req;
    if (!m_valid[i]) begin
      if (rst) begin
        m_valid[i] = 1'b1;
        m_busy[i]  = 1'b0;
        m_rd[i]    = '0;
        m_addr[i]  = '0;
      end
      return;
    end
    ac  = ac_of(i);
    req = wr_en[i] | rd_en[i];
    chk("fixed_strobes", {61'd0, fixed_n}, 64'd0);
    if (m_busy[i]) begin
      n = m_wr[i] ? 2 : 4;
      e = cyc - m_t0[i];
      if (e <= n * ac) begin
        k  = e - 1;
        s  = k / ac;
        ph = k % ac;
        chk("access_ready", {63'd0, rdy}, 64'd0);
        chk("access_addr", {46'd0, a}, {46'd0, 18'(m_base[i] + s)});
        chk("access_we_n", {63'd0, we_n}, {63'd0, (m_wr[i] ? (ph == ac - 1) : 1'b1)});
        chk("access_oe_n", {63'd0, oe_n}, {63'd0, m_wr[i]});
        if (m_wr[i]) chk("write_dq", {48'd0, dq}, {48'd0, (s == 0) ? m_wdata[i][15:0] : m_wdata[i][31:16]});
      end else begin
        m_addr[i] = 18'(m_base[i] + n - 1);
        if (!m_wr[i]) m_rd[i] = m_exp[i];
        chk("done_ready", {63'd0, rdy}, 64'd1);
        chk("done_we_n", {63'd0, we_n}, 64'd1);
        chk("done_oe_n", {63'd0, oe_n}, 64'd1);
        chk("done_addr", {46'd0, a}, {46'd0, m_addr[i]});
        chk("done_readData", rd, m_rd[i]);
        m_busy[i] = 1'b0;
      end
    end else begin
      chk("idle_ready", {63'd0, rdy}, {63'd0, !req});
      chk("idle_we_n", {63'd0, we_n}, 64'd1);
      chk("idle_oe_n", {63'd0, oe_n}, 64'd1);
      chk("idle_addr", {46'd0, a}, {46'd0, m_addr[i]});
      chk("idle_readData", rd, m_rd[i]);
      if (req && !rst) begin
        m_busy[i]  = 1'b1;
        m_t0[i]    = cyc;
        m_wr[i]    = wr_en[i];
        m_wdata[i] = wdata_r[i];
        // Halfword index = byte/2, aligned down to 2 (write) or 4 (read).
        m_base[i]  = ((address_r[i] & 32'h7FFFF) >> 1) & (wr_en[i] ? ~32'h1 : ~32'h3);
        if (wr_en[i]) begin
          ref_mem[i][m_base[i]]     = wdata_r[i][15:0];
          ref_mem[i][m_base[i] + 1] = wdata_r[i][31:16];
        end else begin
          m_exp[i] = {ref_mem[i][m_base[i] + 3], ref_mem[i][m_base[i] + 2],
                      ref_mem[i][m_base[i] + 1], ref_mem[i][m_base[i]]};
        end
      end
    end
    if (rst) begin
      m_busy[i] = 1'b0;
      m_rd[i]   = '0;
      m_addr[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    step(0, ready_w[0], we_n_w[0], oe_n_w[0], addr_w[0], rdata_w[0], g_inst[0].dq,
         {ce_n_w[0], ub_n_w[0], lb_n_w[0]});
    step(1, ready_w[1], we_n_w[1], oe_n_w[1], addr_w[1], rdata_w[1], g_inst[1].dq,
         {ce_n_w[1], ub_n_w[1], lb_n_w[1]});
  end

  // ---------------- stimulus ----------------
  logic        log_we   [64];
  logic [17:0] log_addr [64];

  // Call at posedge+#1; returns at posedge+#1 of the cycle after ready.
  task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input int drop_at, output int lat);
    int t0, idx;
    address_r[i] = a;
    wdata_r[i]   = d;
    wr_en[i]     = wr;
    rd_en[i]     = !wr;
    lat = -1;
    t0  = cyc;
    for (int w = 0; w < 60 && lat < 0; w++) begin
      @(negedge clk);
      idx = cyc - t0;
      if (idx < 64) begin
        log_we[idx]   = we_n_w[i];
        log_addr[idx] = addr_w[i];
      end
      if (ready_w[i]) lat = idx;
      @(posedge clk);
      #1;
      if (lat >= 0 || (drop_at > 0 && (cyc - t0) == drop_at)) begin
        wr_en[i] = 1'b0;
        rd_en[i] = 1'b0;
      end
    end
    wr_en[i] = 1'b0;
    rd_en[i] = 1'b0;
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL txn_timeout: inst %0d no ready within 60 cycles, required ready", i);
    end
    $display("txn inst=%0d %s addr=%08h wdata=%08h drop=%0d lat=%0d readData=%016h",
             i, wr ? "WR" : "RD", a, d, drop_at, lat, rdata_w[i]);
  endtask

  initial begin
    int lat, i, gap, drop, n_slots;
    bit wr;
    logic [31:0] a, d;
    for (int j = 0; j < 2; j++) begin
      address_r[j] = '0;
      wdata_r[j]   = '0;
      wr_en[j]     = 1'b0;
      rd_en[j]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    @(negedge clk);
    chk("reset_ready", {63'd0, ready_w[0]}, 64'd1);
    chk("reset_we_n", {63'd0, we_n_w[0]}, 64'd1);
    chk("reset_oe_n", {63'd0, oe_n_w[0]}, 64'd1);
    chk("reset_readData", rdata_w[0], 64'd0);
    chk("reset_addr", {46'd0, addr_w[0]}, 64'd0);
    @(posedge clk);
    #1;

    // Single write, AC=2.
    txn(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0, lat);
    chk("wr_latency", lat, 5);
    chk("wr_we_pattern", {60'd0, log_we[1], log_we[2], log_we[3], log_we[4]}, 64'b0101);
    chk("wr_hw4", {48'd0, g_inst[0].mem[4]}, 64'hBEEF);
    chk("wr_hw5", {48'd0, g_inst[0].mem[5]}, 64'hDEAD);

    // Preload 4..7 back-to-back, then block read.
    txn(0, 1'b1, 32'h0000_0008, 32'h2222_1111, 0, lat);
    txn(0, 1'b1, 32'h0000_000C, 32'h4444_3333, 0, lat);
    txn(0, 1'b0, 32'h0000_000C, 32'h0, 0, lat);
    chk("rd_latency", lat, 9);
    chk("rd_data", rdata_w[0], 64'h4444_3333_2222_1111);

    // Request dropped in cycle 3 still completes.
    txn(0, 1'b0, 32'h0000_0008, 32'h0, 3, lat);
    chk("drop_latency", lat, 9);
    @(negedge clk);
    chk("drop_back_idle", {63'd0, ready_w[0]}, 64'd1);
    @(posedge clk);
    #1;

    // Reset in cycle 4 of a read.
    address_r[0] = 32'h0000_000C;
    rd_en[0] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_en[0] = 1'b0;
    @(negedge clk);
    chk("midrst_readData", rdata_w[0], 64'd0);
    chk("midrst_we_n", {63'd0, we_n_w[0]}, 64'd1);
    chk("midrst_oe_n", {63'd0, oe_n_w[0]}, 64'd1);
    chk("midrst_ready", {63'd0, ready_w[0]}, 64'd1);
    @(posedge clk);
    #1;
    txn(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 0, lat);
    chk("postrst_wr_latency", lat, 5);

    // AC=3 top-of-memory read.
    txn(1, 1'b1, 32'h0007_FFF8, 32'hBBBB_AAAA, 0, lat);
    chk("ac3_wr_latency", lat, 7);
    txn(1, 1'b1, 32'h0007_FFFC, 32'hDDDD_CCCC, 0, lat);
    txn(1, 1'b0, 32'h0007_FFF8, 32'h0, 0, lat);
    chk("ac3_rd_latency", lat, 13);
    chk("ac3_rd_data", rdata_w[1], 64'hDDDD_CCCC_BBBB_AAAA);
    for (int c = 1; c <= 12; c++) begin
      chk("ac3_addr_seq", {46'd0, log_addr[c]}, {46'd0, 18'h3FFFC + 18'((c - 1) / 3)});
    end

    // Randomized traffic on both instances.
    for (int t = 0; t < 200; t++) begin
      i  = t % 2;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom();
      if ($urandom_range(0, 2) != 0) a[18:6] = 13'h1FFF;
      d  = $urandom();
      n_slots = wr ? 2 : 4;
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n_slots * ac_of(i)) : 0;
      gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      txn(i, wr, a, d, drop, lat);
      chk("rand_latency", lat, n_slots * ac_of(i) + 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
